// File: rtl/axi_xbar_pkg.sv
// Shared defaults for the AXI read-address crossbar: widths, payload struct and address map.
package axi_xbar_pkg;

  localparam int unsigned DefNumM  = 2;
  localparam int unsigned DefNumS  = 6;
  localparam int unsigned DefIdW   = 4;
  localparam int unsigned DefMidW  = 4;
  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefLenW  = 4;
  localparam int unsigned DefSizeW = 3;

  typedef struct packed {
    logic [DefIdW+DefMidW-1:0] id;
    logic [DefAddrW-1:0]       addr;
    logic [DefLenW-1:0]        len;
    logic [DefSizeW-1:0]       size;
    logic [1:0]                burst;
  } ar_payload_t;

  // Slave s owns the 64 KiB window starting at s<<16.
  localparam logic [DefNumS-1:0][DefAddrW-1:0] DefSlvBase = {
    32'h0005_0000, 32'h0004_0000, 32'h0003_0000,
    32'h0002_0000, 32'h0001_0000, 32'h0000_0000
  };
  localparam logic [DefNumS-1:0][DefAddrW-1:0] DefSlvMask = {DefNumS{32'hFFFF_0000}};

endpackage

// File: rtl/axi_ar_xbar_if.sv
// N-port AXI read-address bundle; 'master' drives requests, 'slave' returns ready.
interface axi_ar_xbar_if #(
  parameter int unsigned N      = 2,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned SIZE_W = 3
) ();

  logic [N-1:0][ID_W-1:0]   arid;
  logic [N-1:0][ADDR_W-1:0] araddr;
  logic [N-1:0][LEN_W-1:0]  arlen;
  logic [N-1:0][SIZE_W-1:0] arsize;
  logic [N-1:0][1:0]        arburst;
  logic [N-1:0]             arvalid;
  logic [N-1:0]             arready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready
  );

endinterface

// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after its pointer, advancing past the
// winner when the grant is consumed.
module axi_rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            found;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    // First pass: requesters at or after the pointer; second pass wraps around.
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && req_i[j] && (j >= 32'(ptr_q))) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        if (advance_i) ptr_d = PtrW'((j + 1) % N);
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        if (advance_i) ptr_d = PtrW'((j + 1) % N);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/axi_ar_xbar.sv
// AXI read-address crossbar: address decode, per-slave round-robin arbitration into a one-entry
// output register, and an always-ready sink reporting unmapped requests on the decerr channel.
module axi_ar_xbar
  import axi_xbar_pkg::*;
#(
  parameter int unsigned NUM_M  = DefNumM,
  parameter int unsigned NUM_S  = DefNumS,
  parameter int unsigned ID_W   = DefIdW,
  parameter int unsigned MID_W  = DefMidW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned LEN_W  = DefLenW,
  parameter int unsigned SIZE_W = DefSizeW,
  parameter logic [NUM_S-1:0][ADDR_W-1:0] SLV_BASE = DefSlvBase,
  parameter logic [NUM_S-1:0][ADDR_W-1:0] SLV_MASK = DefSlvMask
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  axi_ar_xbar_if.slave            mst,
  axi_ar_xbar_if.master           slv,
  output logic                    decerr_valid,
  output logic [ID_W+MID_W-1:0]   decerr_id,
  output logic [LEN_W-1:0]        decerr_len
);

  localparam int unsigned SidW = ID_W + MID_W;

  // Local payload type: the package struct only matches the default widths.
  typedef struct packed {
    logic [SidW-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [SIZE_W-1:0] size;
    logic [1:0]        burst;
  } pld_t;

  logic [NUM_M-1:0][NUM_S-1:0] sel;
  logic [NUM_S-1:0][NUM_M-1:0] req_s, gnt_s;
  logic [NUM_M-1:0]            err_req, err_gnt, arready;
  logic [NUM_S-1:0]            load_ok;
  pld_t [NUM_M-1:0]            mst_pld;

  always_comb begin
    sel     = '0;
    err_req = '0;
    mst_pld = '0;
    req_s   = '0;
    for (int m = 0; m < NUM_M; m++) begin
      // Descending scan so the lowest matching slave overwrites any higher one.
      for (int s = NUM_S - 1; s >= 0; s--) begin
        if ((mst.araddr[m] & SLV_MASK[s]) == SLV_BASE[s]) begin
          sel[m]    = '0;
          sel[m][s] = 1'b1;
        end
      end
      err_req[m]       = mst.arvalid[m] && (sel[m] == '0);
      mst_pld[m].id    = {MID_W'(m), mst.arid[m]};
      mst_pld[m].addr  = mst.araddr[m];
      mst_pld[m].len   = mst.arlen[m];
      mst_pld[m].size  = mst.arsize[m];
      mst_pld[m].burst = mst.arburst[m];
      for (int s = 0; s < NUM_S; s++) req_s[s][m] = mst.arvalid[m] && sel[m][s];
    end
  end

  for (genvar s = 0; s < NUM_S; s++) begin : g_slv
    logic vld_q, vld_d;
    pld_t pld_q, pld_d;

    axi_rr_arbiter #(
      .N (NUM_M)
    ) u_arb (
      .clk_i     (ACLK),
      .rst_ni    (ARESETn),
      .req_i     (req_s[s]),
      .advance_i (load_ok[s]),
      .gnt_o     (gnt_s[s])
    );

    assign load_ok[s] = !vld_q || slv.arready[s];

    always_comb begin
      vld_d = vld_q && !slv.arready[s];
      pld_d = pld_q;
      for (int m = 0; m < NUM_M; m++) begin
        if (load_ok[s] && gnt_s[s][m]) begin
          vld_d = 1'b1;
          pld_d = mst_pld[m];
        end
      end
    end

    always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
        vld_q <= 1'b0;
        pld_q <= '0;
      end else begin
        vld_q <= vld_d;
        pld_q <= pld_d;
      end
    end

    assign slv.arvalid[s] = vld_q;
    assign slv.arid[s]    = pld_q.id;
    assign slv.araddr[s]  = pld_q.addr;
    assign slv.arlen[s]   = pld_q.len;
    assign slv.arsize[s]  = pld_q.size;
    assign slv.arburst[s] = pld_q.burst;
  end

  // Error sink never stalls, so its arbiter advances on every grant.
  axi_rr_arbiter #(
    .N (NUM_M)
  ) u_err_arb (
    .clk_i     (ACLK),
    .rst_ni    (ARESETn),
    .req_i     (err_req),
    .advance_i (1'b1),
    .gnt_o     (err_gnt)
  );

  logic              dv_q, dv_d;
  logic [SidW-1:0]   did_q, did_d;
  logic [LEN_W-1:0]  dlen_q, dlen_d;

  always_comb begin
    dv_d   = |err_gnt;
    did_d  = did_q;
    dlen_d = dlen_q;
    for (int m = 0; m < NUM_M; m++) begin
      if (err_gnt[m]) begin
        did_d  = mst_pld[m].id;
        dlen_d = mst_pld[m].len;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      dv_q   <= 1'b0;
      did_q  <= '0;
      dlen_q <= '0;
    end else begin
      dv_q   <= dv_d;
      did_q  <= did_d;
      dlen_q <= dlen_d;
    end
  end

  assign decerr_valid = dv_q;
  assign decerr_id    = did_q;
  assign decerr_len   = dlen_q;

  // Each master hits one target, so its ready is the OR of all its grants.
  always_comb begin
    arready = err_gnt;
    for (int s = 0; s < NUM_S; s++) begin
      for (int m = 0; m < NUM_M; m++) arready[m] = arready[m] | (gnt_s[s][m] & load_ok[s]);
    end
    if (!ARESETn) arready = '0;
  end

  assign mst.arready = arready;

endmodule

// File: tb/tb_axi_ar_xbar.sv
// Directed bench for axi_ar_xbar: decode, round-robin, backpressure, decode errors and reset.
module tb_axi_ar_xbar;

  logic       clk;
  logic       rstn;
  logic       decerr_valid;
  logic [7:0] decerr_id;
  logic [3:0] decerr_len;
  int         checks;
  int         errors;

  axi_ar_xbar_if #(.N(2), .ID_W(4), .ADDR_W(32), .LEN_W(4), .SIZE_W(3)) m_if ();
  axi_ar_xbar_if #(.N(6), .ID_W(8), .ADDR_W(32), .LEN_W(4), .SIZE_W(3)) s_if ();

  axi_ar_xbar #(
    .NUM_M  (2),
    .NUM_S  (6),
    .ID_W   (4),
    .MID_W  (4),
    .ADDR_W (32),
    .LEN_W  (4),
    .SIZE_W (3)
  ) dut (
    .ACLK         (clk),
    .ARESETn      (rstn),
    .mst          (m_if),
    .slv          (s_if),
    .decerr_valid (decerr_valid),
    .decerr_id    (decerr_id),
    .decerr_len   (decerr_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_if.arvalid = '0;
    m_if.arid    = '0;
    m_if.araddr  = '0;
    m_if.arlen   = '0;
    m_if.arsize  = '0;
    m_if.arburst = '0;
    s_if.arready = '1;
  endtask

  task automatic set_m(input int m, input logic [31:0] addr, input logic [3:0] id,
                       input logic [3:0] len);
    m_if.araddr[m]  = addr;
    m_if.arid[m]    = id;
    m_if.arlen[m]   = len;
    m_if.arsize[m]  = 3'd2;
    m_if.arburst[m] = 2'd1;
    m_if.arvalid[m] = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle();
    set_m(0, 32'h0001_0000, 4'h1, 4'h0);
    cyc();
    cyc();
    checks++;
    if (m_if.arready !== 2'b00) begin
      errors++; $display("FAIL reset_arready: got %b want 00", m_if.arready);
    end
    checks++;
    if (s_if.arvalid !== 6'b0) begin
      errors++; $display("FAIL reset_arvalid_s: got %b want 000000", s_if.arvalid);
    end
    checks++;
    if (s_if.araddr !== '0) begin
      errors++; $display("FAIL reset_araddr_s: got %h want 0", s_if.araddr);
    end
    checks++;
    if ({decerr_valid, decerr_id, decerr_len} !== 13'h0) begin
      errors++; $display("FAIL reset_decerr: got %b/%h/%h want 0/00/0",
                         decerr_valid, decerr_id, decerr_len);
    end
    idle();
    rstn = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    set_m(0, 32'h0001_0040, 4'h5, 4'h3);
    #1;
    checks++;
    if (m_if.arready !== 2'b01) begin
      errors++; $display("FAIL single_arready: got %b want 01", m_if.arready);
    end
    cyc();
    idle();
    checks++;
    if (s_if.arvalid !== 6'b000010) begin
      errors++; $display("FAIL single_arvalid: got %b want 000010", s_if.arvalid);
    end
    checks++;
    if ({s_if.arid[1], s_if.araddr[1], s_if.arlen[1]} !== {8'h05, 32'h0001_0040, 4'h3}) begin
      errors++; $display("FAIL single_payload: got id %h addr %h len %h want 05 00010040 3",
                         s_if.arid[1], s_if.araddr[1], s_if.arlen[1]);
    end
    checks++;
    if ({s_if.arsize[1], s_if.arburst[1]} !== {3'd2, 2'd1}) begin
      errors++; $display("FAIL single_size_burst: got %h/%h want 2/1",
                         s_if.arsize[1], s_if.arburst[1]);
    end
    cyc();
    checks++;
    if (s_if.arvalid !== 6'b0) begin
      errors++; $display("FAIL single_drain: got %b want 000000", s_if.arvalid);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_rdy;
    logic [7:0] exp_id;
    set_m(0, 32'h0002_0000, 4'h1, 4'h0);
    set_m(1, 32'h0002_0100, 4'h2, 4'h1);
    for (int i = 0; i < 4; i++) begin
      exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_id  = (i % 2 == 0) ? 8'h01 : 8'h12;
      #1;
      checks++;
      if (m_if.arready !== exp_rdy) begin
        errors++; $display("FAIL contention_arready[%0d]: got %b want %b", i, m_if.arready,
                           exp_rdy);
      end
      cyc();
      if (i == 3) idle();
      checks++;
      if (s_if.arvalid[2] !== 1'b1 || s_if.arid[2] !== exp_id) begin
        errors++; $display("FAIL contention_s2[%0d]: got valid %b id %h want 1 %h", i,
                           s_if.arvalid[2], s_if.arid[2], exp_id);
      end
    end
    cyc();
    checks++;
    if (s_if.arvalid !== 6'b0) begin
      errors++; $display("FAIL contention_drain: got %b want 000000", s_if.arvalid);
    end
  endtask

  task automatic test_backpressure();
    s_if.arready[0] = 1'b0;
    set_m(0, 32'h0000_0100, 4'h3, 4'h1);
    #1;
    checks++;
    if (m_if.arready !== 2'b01) begin
      errors++; $display("FAIL bp_first_accept: got %b want 01", m_if.arready);
    end
    cyc();
    m_if.arvalid[0] = 1'b0;
    set_m(1, 32'h0000_0200, 4'h9, 4'h2);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (m_if.arready !== 2'b00) begin
        errors++; $display("FAIL bp_stall_arready[%0d]: got %b want 00", i, m_if.arready);
      end
      checks++;
      if ({s_if.arvalid[0], s_if.araddr[0], s_if.arid[0]} !== {1'b1, 32'h0000_0100, 8'h03})
      begin
        errors++; $display("FAIL bp_stall_hold[%0d]: got %b %h %h want 1 00000100 03", i,
                           s_if.arvalid[0], s_if.araddr[0], s_if.arid[0]);
      end
      cyc();
    end
    s_if.arready[0] = 1'b1;
    #1;
    checks++;
    if (m_if.arready !== 2'b10) begin
      errors++; $display("FAIL bp_release_arready: got %b want 10", m_if.arready);
    end
    cyc();
    idle();
    checks++;
    if ({s_if.arvalid[0], s_if.araddr[0], s_if.arid[0]} !== {1'b1, 32'h0000_0200, 8'h19}) begin
      errors++; $display("FAIL bp_reload: got %b %h %h want 1 00000200 19",
                         s_if.arvalid[0], s_if.araddr[0], s_if.arid[0]);
    end
    cyc();
    checks++;
    if (s_if.arvalid !== 6'b0) begin
      errors++; $display("FAIL bp_drain: got %b want 000000", s_if.arvalid);
    end
  endtask

  task automatic test_parallel();
    set_m(0, 32'h0003_0010, 4'hA, 4'h4);
    set_m(1, 32'h0005_0020, 4'hB, 4'h5);
    #1;
    checks++;
    if (m_if.arready !== 2'b11) begin
      errors++; $display("FAIL parallel_arready: got %b want 11", m_if.arready);
    end
    cyc();
    idle();
    checks++;
    if (s_if.arvalid !== 6'b101000) begin
      errors++; $display("FAIL parallel_arvalid: got %b want 101000", s_if.arvalid);
    end
    checks++;
    if ({s_if.arid[3], s_if.araddr[3], s_if.arid[5], s_if.araddr[5]} !==
        {8'h0A, 32'h0003_0010, 8'h1B, 32'h0005_0020}) begin
      errors++; $display("FAIL parallel_payload: got %h %h %h %h want 0a 00030010 1b 00050020",
                         s_if.arid[3], s_if.araddr[3], s_if.arid[5], s_if.araddr[5]);
    end
    cyc();
  endtask

  task automatic test_unmapped();
    set_m(1, 32'hF000_0000, 4'h7, 4'h2);
    #1;
    checks++;
    if (m_if.arready !== 2'b10 || decerr_valid !== 1'b0) begin
      errors++; $display("FAIL unmapped_accept: got rdy %b dv %b want 10 0", m_if.arready,
                         decerr_valid);
    end
    cyc();
    idle();
    checks++;
    if ({decerr_valid, decerr_id, decerr_len} !== {1'b1, 8'h17, 4'h2}) begin
      errors++; $display("FAIL unmapped_decerr: got %b %h %h want 1 17 2",
                         decerr_valid, decerr_id, decerr_len);
    end
    checks++;
    if (s_if.arvalid !== 6'b0) begin
      errors++; $display("FAIL unmapped_no_slave: got %b want 000000", s_if.arvalid);
    end
    cyc();
    checks++;
    if (decerr_valid !== 1'b0) begin
      errors++; $display("FAIL unmapped_pulse_width: got %b want 0", decerr_valid);
    end
    // Two unmapped masters at once; 0x0006_0000 sits just past the last slave window.
    set_m(0, 32'h0006_0000, 4'h4, 4'h1);
    set_m(1, 32'hF000_0000, 4'h6, 4'h3);
    #1;
    checks++;
    if (m_if.arready !== 2'b01) begin
      errors++; $display("FAIL unmapped_dual_first: got %b want 01", m_if.arready);
    end
    cyc();
    m_if.arvalid[0] = 1'b0;
    checks++;
    if ({decerr_valid, decerr_id, decerr_len} !== {1'b1, 8'h04, 4'h1}) begin
      errors++; $display("FAIL unmapped_dual_d0: got %b %h %h want 1 04 1",
                         decerr_valid, decerr_id, decerr_len);
    end
    #1;
    checks++;
    if (m_if.arready !== 2'b10) begin
      errors++; $display("FAIL unmapped_dual_second: got %b want 10", m_if.arready);
    end
    cyc();
    idle();
    checks++;
    if ({decerr_valid, decerr_id, decerr_len, s_if.arvalid} !== {1'b1, 8'h16, 4'h3, 6'b0}) begin
      errors++; $display("FAIL unmapped_dual_d1: got %b %h %h %b want 1 16 3 000000",
                         decerr_valid, decerr_id, decerr_len, s_if.arvalid);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    s_if.arready[4] = 1'b0;
    set_m(0, 32'h0002_0000, 4'h3, 4'h0);
    set_m(1, 32'h0004_0000, 4'h5, 4'h0);
    #1;
    checks++;
    if (m_if.arready !== 2'b11) begin
      errors++; $display("FAIL rstmid_setup: got %b want 11", m_if.arready);
    end
    cyc();
    m_if.arvalid = '0;
    checks++;
    if (s_if.arvalid !== 6'b010100) begin
      errors++; $display("FAIL rstmid_loaded: got %b want 010100", s_if.arvalid);
    end
    rstn = 1'b0;
    set_m(0, 32'h0002_0000, 4'h3, 4'h0);
    #1;
    checks++;
    if (m_if.arready !== 2'b00) begin
      errors++; $display("FAIL rstmid_arready: got %b want 00", m_if.arready);
    end
    cyc();
    checks++;
    if ({s_if.arvalid, decerr_valid, s_if.arid[4]} !== {6'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL rstmid_cleared: got %b %b %h want 000000 0 00",
                         s_if.arvalid, decerr_valid, s_if.arid[4]);
    end
    rstn = 1'b1;
    idle();
    set_m(0, 32'h0002_0000, 4'h3, 4'h0);
    set_m(1, 32'h0002_0010, 4'h8, 4'h0);
    #1;
    checks++;
    if (m_if.arready !== 2'b01) begin
      errors++; $display("FAIL rstmid_first_grant: got %b want 01", m_if.arready);
    end
    cyc();
    idle();
    checks++;
    if (s_if.arid[2] !== 8'h03) begin
      errors++; $display("FAIL rstmid_first_id: got %h want 03", s_if.arid[2]);
    end
    cyc();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_parallel();
    test_unmapped();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_ar_xbar.md
# axi_ar_xbar

Parametrised AXI read-address crossbar for the interconnect: routes AR requests from NUM_M masters to NUM_S slaves, decoding each master's ARADDR against a per-slave address map. It arbitrates round-robin per slave and registers each slave-side AR output in a one-entry pipeline stage. Requests that hit no slave are absorbed internally and reported on a DECERR side channel, so the read-data channel can return an error response.

## Interface
Parameters:
- NUM_M, 2: number of masters.
- NUM_S, 6: number of slaves.
- ID_W, 4: master-side ARID width.
- MID_W, 4: master-index field prepended to the ID; slave ARID width is ID_W+MID_W. Requires NUM_M ≤ 2^MID_W.
- ADDR_W, 32: address width.
- LEN_W, 4: ARLEN width.
- SIZE_W, 3: ARSIZE width.
- SLV_BASE, slave s = s<<16: per-slave base address, [NUM_S][ADDR_W].
- SLV_MASK, all 0xFFFF_0000: per-slave address mask, [NUM_S][ADDR_W].

Ports:
- ACLK  in  1  clock; all logic is rising-edge.
- ARESETn  in  1  reset, synchronous and active-low.
- ARID_M  in  [NUM_M][ID_W]  master IDs.
- ARADDR_M  in  [NUM_M][ADDR_W]  master addresses.
- ARLEN_M  in  [NUM_M][LEN_W]  master burst lengths.
- ARSIZE_M  in  [NUM_M][SIZE_W]  master transfer sizes.
- ARBURST_M  in  [NUM_M][2]  master burst types.
- ARVALID_M  in  [NUM_M]  master request valids.
- ARREADY_M  out  [NUM_M]  master accept strobes.
- ARID_S  out  [NUM_S][ID_W+MID_W]  slave IDs, {master index, ARID}.
- ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S  out  per-slave payload, widths as on the master side.
- ARVALID_S  out  [NUM_S]  slave request valids.
- ARREADY_S  in  [NUM_S]  slave accept strobes.
- decerr_valid  out  1  single-cycle pulse when an unmapped request is accepted.
- decerr_id  out  ID_W+MID_W  {master index, ARID} of the unmapped request.
- decerr_len  out  LEN_W  ARLEN of the unmapped request.

## Operation
- Decode: master m targets slave s when (ARADDR_M[m] & SLV_MASK[s]) == SLV_BASE[s]. On overlapping regions the lowest s wins. No match targets the internal error sink.
- Each slave s has one output register: a valid bit plus payload. The register may load when it is empty or draining: load_ok[s] = !ARVALID_S[s] || ARREADY_S[s].
- Arbitration, per slave: among masters with ARVALID and a decode hit on s, pick the first at or after rr_ptr[s] in cyclic order.
- Accept: when load_ok[s] is high, the winner gets ARREADY_M high the same cycle. Its payload and {m[MID_W-1:0], ARID} load into the register at the edge, and rr_ptr[s] becomes (winner+1) mod NUM_M. Losers see ARREADY_M low and hold their request.
- Drain: the register clears when ARREADY_S[s] is high and nothing new loads. If it drains and reloads in the same cycle, ARVALID_S stays high and the payload is replaced, giving back-to-back throughput of 1 per cycle per slave.
- Error sink: always ready. ARREADY_M[m] is high for any master whose valid request decodes to no slave. Simultaneous unmapped requests are served round-robin on rr_ptr_err, one per cycle. The acceptance edge produces a registered decerr_valid pulse (1 cycle) with decerr_id/decerr_len.
- Each master decodes to exactly one target per cycle, so ARREADY_M[m] is the OR of its grants.
- Payload on a slave port is held stable while ARVALID_S is high and ARREADY_S is low (AXI stability rule).

## Timing
- Reset (ARESETn low at an edge) clears all ARVALID_S, all payload registers, decerr_valid, decerr_id and decerr_len to 0, and resets every rr_ptr to 0.
- ARREADY_M is forced to 0 while ARESETn is low. Requests in flight at reset are dropped.
- Latency: master handshake at edge N gives ARVALID_S high from N+1.
- ARREADY_M is combinational from ARVALID_M, ARADDR_M and ARREADY_S. This path is documented; there is no combinational path from ARVALID_M to ARVALID_S.
- Slave stalled (ARVALID_S=1, ARREADY_S=0): load_ok=0, so every master targeting s sees ARREADY_M=0.
- A master that drops ARVALID before it is granted is simply not considered; the pointer is unchanged.
- NUM_M=1 is legal: arbitration degenerates and the master-index field is 0.

## Structure
- Package axi_xbar_pkg: default widths, the ar_payload_t struct (id, addr, len, size, burst), and the default SLV_BASE/SLV_MASK constants.
- Sub-module axi_rr_arbiter (parameter N): inputs req[N] and an advance strobe; outputs a one-hot grant and holds its own pointer. It is instantiated NUM_S+1 times, once per slave plus one for the error sink.
- The top level is a generate loop over slaves holding the decode, load_ok logic and output registers.

## Test plan
- Single request: M0 ARADDR=0x0001_0040, ARLEN=3 → ARREADY_M0 at edge N; at N+1 ARVALID_S1=1, ARID_S1={4'h0,ID}, ARADDR_S1=0x0001_0040, ARLEN_S1=3.
- Contention: M0 and M1 both target S2 every cycle with ARREADY_S2=1 → grants alternate M0, M1, M0, M1; ARVALID_S2 stays high for 4 consecutive cycles.
- Backpressure: ARREADY_S0=0 for 5 cycles with M1 pending → ARVALID_S0 and payload stay stable and ARREADY_M1=0; the cycle ARREADY_S0 rises, M1 is accepted and S0 reloads with no bubble.
- Parallel: M0→S3 and M1→S5 in the same cycle → both ARREADY_M high; ARVALID_S3 and ARVALID_S5 high next cycle.
- Unmapped: M1 ARADDR=0xF000_0000, ID=7 → ARREADY_M1=1; next cycle decerr_valid=1 for exactly 1 cycle with decerr_id={4'h1,4'h7}; no ARVALID_S asserted.
- Reset mid-operation: ARESETn low while ARVALID_S4=1 → after that edge all ARVALID_S=0 and decerr_valid=0; the first post-reset contention grants M0 first.
